mem_in_arb: RTL and testbench

Parametrised multi-channel memory-request input stage. It accepts write/read requests from CH_NUM independent requesters, buffers each channel in its own FIFO, and arbitrates round-robin onto a single registered memory request port. It sits between the requester-side interfaces driven by the memory input agent and the memory model/controller. It generalises the earlier single-channel, fixed-width input path to configurable width, depth and channel count, with per-channel backpressure.

---
 rtl/mem_in_arb_pkg.sv | 27 ++
 rtl/mem_in_fifo.sv | 81 ++++++++
 rtl/mem_in_arb.sv | 172 +++++++++++++++++
 tb/tb_mem_in_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_in_arb_pkg.sv
// rtl/mem_in_arb_pkg.sv - shared types and helpers for the memory request input stage
//
// Purpose: request struct at default widths, round-robin pointer type and
// the channel-index width helper used by mem_in_arb.
// Ports: none (package).
package mem_in_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

  // Default-width request record: {wr, addr, data}, same packing as the FIFO entries.
  typedef struct packed {
    logic                  wr;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } mem_req_t;

  // Wide enough for the largest supported channel count (16).
  localparam int RR_PTR_W = 4;
  typedef logic [RR_PTR_W-1:0] rr_ptr_t;

  // Bits needed to name one of n channels (at least one bit).
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_in_fifo.sv
// rtl/mem_in_fifo.sv - single-channel synchronous request FIFO
//
// Purpose: buffers one requester channel; power-of-two depth, natural pointer wrap.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   push_i      write wdata_i (ignored while full_o)
//   pop_i       drop head entry (ignored while empty_o)
//   wdata_i     entry to store
//   rdata_o     head entry
//   cnt_o       occupancy after the last edge
//   full_o      registered "cannot accept"; also held high while in reset
//   empty_o     no entries
module mem_in_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 97
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             wr_en, rd_en;

  assign wr_en = push_i && !full_q;
  assign rd_en = pop_i && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Registered from the next count: a full FIFO popped this cycle still
    // refuses this cycle and reopens on the following one.
    full_d = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      // Refuse pushes during reset; space is advertised one cycle after release.
      full_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  assign full_o  = full_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mem_in_arb.sv
// rtl/mem_in_arb.sv - multi-channel memory request input stage with round-robin arbitration
//
// Purpose: one FIFO per requester channel, round-robin grant onto a single
// registered memory request port. Optional parity: define MEM_IN_PARITY_EN.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     per-channel request valid          in_ready  per-channel accept
//   in_wr        per-channel 1 = write, 0 = read
//   in_addr      packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   in_data      packed write data, channel i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready  output handshake
//   out_wr, out_addr, out_data, out_ch  registered request and its source channel
//   out_par      even parity over {out_wr,out_addr,out_data} (MEM_IN_PARITY_EN only)
//   fifo_cnt     packed per-channel occupancy
module mem_in_arb
  import mem_in_arb_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CH_NUM-1:0]                 in_valid,
  output logic [CH_NUM-1:0]                 in_ready,
  input  logic [CH_NUM-1:0]                 in_wr,
  input  logic [CH_NUM*ADDR_W-1:0]          in_addr,
  input  logic [CH_NUM*DATA_W-1:0]          in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_wr,
  output logic [ADDR_W-1:0]                 out_addr,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(CH_NUM)-1:0]         out_ch,
`ifdef MEM_IN_PARITY_EN
  output logic                              out_par,
`endif
  output logic [CH_NUM*$clog2(DEPTH+1)-1:0] fifo_cnt
);

  localparam int CH_W  = ch_idx_w(CH_NUM);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int REQ_W = 1 + ADDR_W + DATA_W;
  // One extra bit so rr_ptr + offset never overflows before the wrap subtract.
  localparam int IDX_W = RR_PTR_W + 1;

  logic [CH_NUM-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]  fifo_head [CH_NUM];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign fifo_push[g] = in_valid[g] && !fifo_full[g];

    mem_in_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REQ_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push[g]),
      .pop_i   (fifo_pop[g]),
      .wdata_i ({in_wr[g], in_addr[g*ADDR_W +: ADDR_W], in_data[g*DATA_W +: DATA_W]}),
      .rdata_o (fifo_head[g]),
      .cnt_o   (fifo_cnt[g*CW +: CW]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  assign in_ready = ~fifo_full;

  rr_ptr_t          rr_ptr_q, rr_ptr_d;
  rr_ptr_t          grant;
  logic             grant_vld;
  logic [IDX_W-1:0] idx;
  logic [REQ_W-1:0] grant_req;
  logic             load;

  logic              out_valid_q, out_valid_d;
  logic              out_wr_q, out_wr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  // Round-robin search: first non-empty channel at or after rr_ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (idx >= IDX_W'(CH_NUM)) idx = idx - IDX_W'(CH_NUM);
      for (int i = 0; i < CH_NUM; i++) begin
        if (!grant_vld && (idx == IDX_W'(i)) && !fifo_empty[i]) begin
          grant_vld = 1'b1;
          grant     = RR_PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    // Output stage can take a new request when empty or being drained now.
    load      = grant_vld && (!out_valid_q || out_ready);
    grant_req = '0;
    fifo_pop  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (grant == RR_PTR_W'(i)) begin
        grant_req   = fifo_head[i];
        fifo_pop[i] = load;
      end
    end

    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_wr_d    = out_wr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load) begin
      rr_ptr_d    = (grant == RR_PTR_W'(CH_NUM-1)) ? '0 : grant + RR_PTR_W'(1);
      out_valid_d = 1'b1;
      out_wr_d    = grant_req[REQ_W-1];
      out_addr_d  = grant_req[DATA_W +: ADDR_W];
      out_data_d  = grant_req[DATA_W-1:0];
      out_ch_d    = grant[CH_W-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_wr_q    <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_wr_q    <= out_wr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_wr    = out_wr_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef MEM_IN_PARITY_EN
  logic out_par_q, out_par_d;

  always_comb begin
    out_par_d = out_par_q;
    if (load) out_par_d = ^grant_req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_par_q <= 1'b0;
    else        out_par_q <= out_par_d;
  end

  assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_mem_in_arb.sv
// tb/tb_mem_in_arb.sv - self-checking bench for mem_in_arb (default parameters)
module tb_mem_in_arb;
  import mem_in_arb_pkg::*;

  localparam int CH = 4;

  typedef struct {
    int       ch;
    mem_req_t req;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid, in_ready, in_wr;
  logic [127:0] in_addr;
  logic [255:0] in_data;
  logic         out_valid, out_ready, out_wr;
  logic [31:0]  out_addr;
  logic [63:0]  out_data;
  logic [1:0]   out_ch;
  logic [15:0]  fifo_cnt;
`ifdef MEM_IN_PARITY_EN
  logic         out_par;
`endif

  mem_in_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wr     (in_wr),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wr    (out_wr),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_ch    (out_ch),
`ifdef MEM_IN_PARITY_EN
    .out_par   (out_par),
`endif
    .fifo_cnt  (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   seq[CH];
  bit   auto_inc = 0;
  bit   fair_mode = 0;
  int   n_fair = 0;
  int   exp_ch = 0;
  int   hist[CH];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic wr, input logic [31:0] a, input logic [63:0] d);
    in_wr[c]           = wr;
    in_addr[c*32 +: 32] = a;
    in_data[c*64 +: 64] = d;
  endtask

  task automatic check_out();
    int   hit;
    exp_t e;
    hit = -1;
    for (int j = 0; j < exp_q.size(); j++)
      if (hit < 0 && exp_q[j].ch == int'(out_ch)) hit = j;
    chk("sb_entry_found", (hit >= 0), 1'b1);
    if (hit >= 0) begin
      e = exp_q[hit];
      exp_q.delete(hit);
      chk("sb_out_wr", out_wr, e.req.wr);
      chk("sb_out_addr", out_addr, e.req.addr);
      chk("sb_out_data", out_data, e.req.data);
    end
    if (fair_mode && n_fair < 100) begin
      chk("rr_order", out_ch, exp_ch);
      hist[out_ch]++;
      exp_ch = (exp_ch + 1) % CH;
      n_fair++;
    end
  endtask

  // One clock: record pushes and output handshakes before the edge, then
  // return 1 time unit after the edge with outputs settled.
  task automatic tick();
    logic [3:0] pushed;
    exp_t e;
    @(negedge clk);
    pushed = in_valid & in_ready;
    for (int c = 0; c < CH; c++) begin
      if (rst_n && pushed[c]) begin
        e.ch  = c;
        e.req = {in_wr[c], in_addr[c*32 +: 32], in_data[c*64 +: 64]};
        exp_q.push_back(e);
      end
    end
    if (out_valid && out_ready && rst_n) check_out();
    @(posedge clk);
    #1;
    if (auto_inc) begin
      for (int c = 0; c < CH; c++) begin
        if (pushed[c]) begin
          seq[c]++;
          set_req(c, seq[c][0], {8'(c), 24'(seq[c])}, {32'(seq[c]), 32'(c)});
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_wr     = '0;
    in_addr   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int c = 0; c < CH; c++) begin
      seq[c]  = 0;
      hist[c] = 0;
    end

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 4'h0);
    chk("rst_fifo_cnt", fifo_cnt, 16'h0);
    chk("rst_out_ch", out_ch, 2'd0);
    chk("rst_out_wr", out_wr, 1'b0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_data", out_data, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 4'hF);

    // Single write on ch2, two-cycle latency
    set_req(2, 1'b1, 32'h100, 64'hA5);
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    chk("single_lat1_valid", out_valid, 1'b0);
    chk("single_cnt2", fifo_cnt[8 +: 4], 4'd1);
    tick();
    chk("single_valid", out_valid, 1'b1);
    chk("single_ch", out_ch, 2'd2);
    chk("single_wr", out_wr, 1'b1);
    chk("single_addr", out_addr, 32'h100);
    chk("single_data", out_data, 64'hA5);
    chk("single_cnt_after", fifo_cnt, 16'h0);
    tick();
    chk("single_drained", out_valid, 1'b0);

    // Read on ch3 passes stored data through
    set_req(3, 1'b0, 32'h200, 64'h5A);
    in_valid = 4'b1000;
    tick();
    in_valid = '0;
    tick();
    chk("read_ch", out_ch, 2'd3);
    chk("read_wr", out_wr, 1'b0);
    chk("read_data", out_data, 64'h5A);
    tick();

    // Fill ch0 with output stalled, then hold and check stability
    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk("full_ready_before_push", in_ready[0], 1'b1);
      set_req(0, 1'b1, 32'(k), 64'(k * 'h11));
      in_valid = 4'b0001;
      tick();
    end
    in_valid = '0;
    chk("full_in_ready", in_ready[0], 1'b0);
    chk("full_cnt0", fifo_cnt[3:0], 4'd8);
    chk("full_out_valid", out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_ch", out_ch, 2'd0);
      chk("stall_addr", out_addr, 32'h1);
      chk("stall_data", out_data, 64'h11);
      chk("stall_cnt0", fifo_cnt[3:0], 4'd8);
    end
    out_ready = 1'b1;
    drain("full_drain_empty");
    chk("full_ready_after", in_ready[0], 1'b1);
    chk("full_cnt_after", fifo_cnt, 16'h0);

    // Reset with requests in flight on ch1
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b0, 32'h300 + 32'(k), 64'(k));
      in_valid = 4'b0010;
      tick();
    end
    in_valid = '0;
    chk("midrst_cnt1", fifo_cnt[7:4], 4'd2);
    chk("midrst_valid_before", out_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_fifo_cnt", fifo_cnt, 16'h0);
    chk("midrst_in_ready", in_ready, 4'h0);
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("midrst_ready_after", in_ready, 4'hF);
    chk("midrst_valid_after", out_valid, 1'b0);

    // Fairness: all channels continuously valid
    for (int c = 0; c < CH; c++) set_req(c, 1'b0, {8'(c), 24'h0}, {32'h0, 32'(c)});
    exp_ch    = 0;
    fair_mode = 1;
    auto_inc  = 1;
    in_valid  = 4'hF;
    for (int i = 0; i < 400; i++) begin
      if (n_fair >= 100) break;
      tick();
    end
    in_valid  = '0;
    auto_inc  = 0;
    fair_mode = 0;
    chk("fair_count_reached", n_fair, 100);
    for (int c = 0; c < CH; c++) chk("fair_share", hist[c], 25);
    drain("fair_drain_empty");

`ifdef MEM_IN_PARITY_EN
    set_req(0, 1'b1, 32'h1, 64'h0);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    tick();
    chk("par_even", out_par, 1'b0);
    tick();
    set_req(0, 1'b1, 32'h1, 64'h1);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    tick();
    chk("par_odd", out_par, 1'b1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
